// File: rtl/csr_timer_bank.sv
// Multi-channel compare timer on the CSR bus: shared prescaled counter, CHANNELS compare registers, pending/enable, irq.
// Latency: read data one cycle after addr/read; modify acts on the registered address; irq/irq_ch one cycle after pending/enable.
// No backpressure: the CSR bus is fire-and-forget, every access completes in fixed time. Optional: CSR_TIMER_PERIODIC_EN.
module csr_timer_bank #(
    parameter logic [11:0] BASE_ADDR      = 12'hBC4,
    parameter int          WIDTH          = 32,
    parameter int          CHANNELS       = 4,
    parameter int          PRESCALE_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                read,
    input  logic [2:0]          modify,
    input  logic [31:0]         wdata,
    input  logic [11:0]         addr,
    output logic [31:0]         rdata,
    output logic                valid,
    output logic                irq,
    output logic [CHANNELS-1:0] irq_ch,
    output logic                AVOID_WARNING
);

    localparam int CMP_OFF = 4;
    localparam int PER_OFF = 4 + CHANNELS;
`ifdef CSR_TIMER_PERIODIC_EN
    localparam int NREGS   = 4 + 2 * CHANNELS;
`else
    localparam int NREGS   = 4 + CHANNELS;
`endif

    // Apply a CSR modify op to a zero-extended register value; callers truncate.
    function automatic logic [31:0] apply_op(input logic [2:0] op, input logic [31:0] cur,
                                             input logic [31:0] wd);
        logic [31:0] res;
        res = cur;
        case (op)
            3'd1:    res = wd;
            3'd2:    res = cur | wd;
            3'd3:    res = cur & ~wd;
            default: res = cur;
        endcase
        return res;
    endfunction

    logic [11:0]               q_addr_q;
    logic                      q_read_q;
    logic [WIDTH-1:0]          cnt_q, cnt_d;
    logic [PRESCALE_WIDTH-1:0] pcnt_q, pcnt_d;
    logic [PRESCALE_WIDTH-1:0] div_q, div_d;
    logic [CHANNELS-1:0]       pend_q, pend_d;
    logic [CHANNELS-1:0]       en_q, en_d;
    logic [WIDTH-1:0]          cmp_q [CHANNELS];
    logic [WIDTH-1:0]          cmp_d [CHANNELS];
`ifdef CSR_TIMER_PERIODIC_EN
    logic [WIDTH-1:0]          per_q [CHANNELS];
    logic [WIDTH-1:0]          per_d [CHANNELS];
`endif
    logic                      irq_q;
    logic [CHANNELS-1:0]       irq_ch_q;

    logic [11:0]               off;
    logic                      sel;
    logic                      op_act;
    logic                      tick;
    logic                      cnt_mod;
    logic                      div_mod;
    logic                      pend_mod;
    logic                      en_mod;
    logic [WIDTH-1:0]          cnt_inc;
    logic [CHANNELS-1:0]       match;
    logic [31:0]               rd_mux;

    // Offset wraps for addresses below the base, so one compare covers the whole decode.
    assign off     = q_addr_q - BASE_ADDR;
    assign sel     = (off < 12'(NREGS));
    assign op_act  = sel && (modify == 3'd1 || modify == 3'd2 || modify == 3'd3);
    assign cnt_mod  = op_act && (off == 12'd0);
    assign div_mod  = op_act && (off == 12'd1);
    assign pend_mod = op_act && (off == 12'd2);
    assign en_mod   = op_act && (off == 12'd3);

    // Prescaler, counter and compare match; CSR writes to COUNT/DIV suppress the tick effects.
    always_comb begin
        tick    = (pcnt_q == div_q) && !div_mod;
        cnt_inc = cnt_q + WIDTH'(1);
        match   = '0;

        if (div_mod || tick) pcnt_d = '0;
        else                 pcnt_d = pcnt_q + PRESCALE_WIDTH'(1);

        div_d = div_mod ? PRESCALE_WIDTH'(apply_op(modify, 32'(div_q), wdata)) : div_q;

        if (cnt_mod)   cnt_d = WIDTH'(apply_op(modify, 32'(cnt_q), wdata));
        else if (tick) cnt_d = cnt_inc;
        else           cnt_d = cnt_q;

        for (int i = 0; i < CHANNELS; i++) begin
            match[i] = tick && !cnt_mod && (cnt_inc == cmp_q[i]);
        end

        // A hardware match is ORed in after the software op, so set beats clear.
        pend_d = (pend_mod ? CHANNELS'(apply_op(modify, 32'(pend_q), wdata)) : pend_q) | match;
        en_d   = en_mod ? CHANNELS'(apply_op(modify, 32'(en_q), wdata)) : en_q;
    end

    // Per-channel compare (and period) next state; software writes take priority over auto-advance.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            cmp_d[i] = cmp_q[i];
            if (op_act && off == 12'(CMP_OFF + i)) begin
                cmp_d[i] = WIDTH'(apply_op(modify, 32'(cmp_q[i]), wdata));
            end
`ifdef CSR_TIMER_PERIODIC_EN
            else if (match[i] && per_q[i] != '0) begin
                cmp_d[i] = cmp_q[i] + per_q[i];
            end
            per_d[i] = per_q[i];
            if (op_act && off == 12'(PER_OFF + i)) begin
                per_d[i] = WIDTH'(apply_op(modify, 32'(per_q[i]), wdata));
            end
`endif
        end
    end

    // Read mux over the registered address; reads are zero-extended.
    always_comb begin
        rd_mux = '0;
        if (off == 12'd0) rd_mux = 32'(cnt_q);
        if (off == 12'd1) rd_mux = 32'(div_q);
        if (off == 12'd2) rd_mux = 32'(pend_q);
        if (off == 12'd3) rd_mux = 32'(en_q);
        for (int i = 0; i < CHANNELS; i++) begin
            if (off == 12'(CMP_OFF + i)) rd_mux = 32'(cmp_q[i]);
`ifdef CSR_TIMER_PERIODIC_EN
            if (off == 12'(PER_OFF + i)) rd_mux = 32'(per_q[i]);
`endif
        end
    end

    assign valid         = sel;
    assign rdata         = (q_read_q && sel) ? rd_mux : 32'd0;
    assign irq           = irq_q;
    assign irq_ch        = irq_ch_q;
    assign AVOID_WARNING = 1'b0;

    // State registers; reset clears everything, including the registered interrupt outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q_addr_q <= '0;
            q_read_q <= 1'b0;
            cnt_q    <= '0;
            pcnt_q   <= '0;
            div_q    <= '0;
            pend_q   <= '0;
            en_q     <= '0;
            irq_q    <= 1'b0;
            irq_ch_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cmp_q[i] <= '0;
`ifdef CSR_TIMER_PERIODIC_EN
                per_q[i] <= '0;
`endif
            end
        end else begin
            q_addr_q <= addr;
            q_read_q <= read;
            cnt_q    <= cnt_d;
            pcnt_q   <= pcnt_d;
            div_q    <= div_d;
            pend_q   <= pend_d;
            en_q     <= en_d;
            irq_q    <= |(pend_q & en_q);
            irq_ch_q <= pend_q & en_q;
            for (int i = 0; i < CHANNELS; i++) begin
                cmp_q[i] <= cmp_d[i];
`ifdef CSR_TIMER_PERIODIC_EN
                per_q[i] <= per_d[i];
`endif
            end
        end
    end

endmodule

// File: tb/tb_csr_timer_bank.sv
// Directed bench for csr_timer_bank at default parameters; optional periodic section under CSR_TIMER_PERIODIC_EN.
// Latency: reads sampled on the falling edge one cycle after issue.
// No backpressure on this bus; all waits are fixed cycle counts.
module tb_csr_timer_bank;

    localparam logic [11:0] A_CNT  = 12'hBC4;
    localparam logic [11:0] A_DIV  = 12'hBC5;
    localparam logic [11:0] A_PEND = 12'hBC6;
    localparam logic [11:0] A_EN   = 12'hBC7;
    localparam logic [11:0] A_CMP0 = 12'hBC8;
    localparam logic [11:0] A_PER0 = 12'hBCC;

    logic        clk;
    logic        rstn;
    logic        read;
    logic [2:0]  modify;
    logic [31:0] wdata;
    logic [11:0] addr;
    logic [31:0] rdata;
    logic        valid;
    logic        irq;
    logic [3:0]  irq_ch;
    logic        avoid_warning;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] d;
    logic        v;

    csr_timer_bank u_dut (
        .clk           (clk),
        .rstn          (rstn),
        .read          (read),
        .modify        (modify),
        .wdata         (wdata),
        .addr          (addr),
        .rdata         (rdata),
        .valid         (valid),
        .irq           (irq),
        .irq_ch        (irq_ch),
        .AVOID_WARNING (avoid_warning)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue a read at a falling edge; result sampled at the next falling edge.
    task automatic csr_rd(input logic [11:0] a, output logic [31:0] dat, output logic vld);
        addr = a;
        read = 1'b1;
        @(negedge clk);
        dat  = rdata;
        vld  = valid;
        read = 1'b0;
        addr = 12'h000;
    endtask

    // Address cycle then modify cycle; the op lands on the second rising edge.
    task automatic csr_mod(input logic [11:0] a, input logic [2:0] op, input logic [31:0] wd);
        addr   = a;
        read   = 1'b0;
        modify = 3'd0;
        @(negedge clk);
        addr   = 12'h000;
        modify = op;
        wdata  = wd;
        @(negedge clk);
        modify = 3'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clk = 1'b0; rstn = 1'b0; read = 1'b0; modify = 3'd0; wdata = '0; addr = '0;
        repeat (2) @(negedge clk);
        addr = A_CNT; read = 1'b1;
        @(negedge clk);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_irq_ch", 32'(irq_ch), 32'd0);
        chk("avoid_warning", 32'(avoid_warning), 32'd0);
        read = 1'b0; addr = '0;
        rstn = 1'b1;

        // DIV=0 after reset: counter ticks on the first edge
        csr_rd(A_CNT, d, v);
        chk("cnt_first", d, 32'd1);
        chk("cnt_first_vld", 32'(v), 32'd1);
        for (int i = 1; i < 8; i++) begin
            csr_rd(A_CNT + 12'(i), d, v);
            chk("map_vld", 32'(v), 32'd1);
            chk("map_zero", d, 32'd0);
        end
        csr_rd(A_CNT + 12'd8, d, v);
`ifdef CSR_TIMER_PERIODIC_EN
        chk("per0_vld", 32'(v), 32'd1);
`else
        chk("undecoded_vld", 32'(v), 32'd0);
`endif
        chk("plus8_rdata", d, 32'd0);
        addr = A_CNT; read = 1'b0;
        @(negedge clk);
        chk("noread_vld", 32'(valid), 32'd1);
        chk("noread_rdata", rdata, 32'd0);
        addr = '0;
        chk("irq_idle", 32'(irq), 32'd0);

        // Prescaled count and compare on channel 0
        csr_mod(A_CMP0, 3'd1, 32'd5);
        csr_mod(A_EN, 3'd1, 32'd1);
        csr_mod(A_CNT, 3'd1, 32'd0);
        csr_mod(A_DIV, 3'd1, 32'd3);
        for (int k = 0; k < 4; k++) begin
            csr_rd(A_CNT, d, v);
            chk("div3_cnt", d, (k == 3) ? 32'd2 : 32'd1);
        end
        repeat (11) @(negedge clk);
        csr_rd(A_CNT, d, v);
        chk("cnt_at5", d, 32'd5);
        chk("irq_ch_lag", 32'(irq_ch), 32'd0);
        csr_rd(A_PEND, d, v);
        chk("pend0_set", d, 32'd1);
        chk("irq_ch0", 32'(irq_ch), 32'd1);
        chk("irq_set", 32'(irq), 32'd1);

        // Software clear, then clear colliding with a match
        csr_mod(A_PEND, 3'd3, 32'd1);
        chk("irq_clr_lag", 32'(irq), 32'd1);
        csr_rd(A_PEND, d, v);
        chk("pend0_clr", d, 32'd0);
        chk("irq_clr", 32'(irq), 32'd0);
        csr_mod(A_CMP0, 3'd1, 32'd22);
        csr_mod(A_DIV, 3'd1, 32'd0);
        csr_mod(A_PEND, 3'd2, 32'd1);
        csr_rd(A_PEND, d, v);
        chk("pend_inject", d, 32'd1);
        csr_mod(A_CNT, 3'd1, 32'd20);
        csr_mod(A_PEND, 3'd3, 32'd1);
        csr_rd(A_PEND, d, v);
        chk("set_wins", d, 32'd1);
        csr_rd(A_CNT, d, v);
        chk("cnt_after_clr", d, 32'd24);
        chk("irq_held", 32'(irq), 32'd1);

        // Wrap: all-ones to zero, then match on channel 1
        csr_mod(A_CMP0 + 12'd1, 3'd1, 32'd1);
        csr_mod(A_EN, 3'd1, 32'd2);
        csr_mod(A_PEND, 3'd1, 32'd0);
        csr_mod(A_CNT, 3'd1, 32'hFFFF_FFFE);
        csr_rd(A_CNT, d, v);
        chk("wrap_ff", d, 32'hFFFF_FFFF);
        csr_rd(A_CNT, d, v);
        chk("wrap_00", d, 32'd0);
        chk("wrap_irq_ch_a", 32'(irq_ch), 32'd0);
        csr_rd(A_CNT, d, v);
        chk("wrap_01", d, 32'd1);
        chk("wrap_irq_ch_b", 32'(irq_ch), 32'd0);
        csr_rd(A_PEND, d, v);
        chk("wrap_pend", d, 32'hE);
        chk("wrap_irq_ch1", 32'(irq_ch), 32'd2);
        chk("wrap_irq", 32'(irq), 32'd1);

        // COUNT write landing on a tick
        csr_mod(A_CMP0 + 12'd3, 3'd1, 32'd101);
        csr_mod(A_PEND, 3'd3, 32'hF);
        csr_mod(A_DIV, 3'd1, 32'd3);
        repeat (2) @(negedge clk);
        csr_mod(A_CNT, 3'd1, 32'd100);
        csr_rd(A_CNT, d, v);
        chk("cnt_wr_wins", d, 32'd100);
        csr_rd(A_PEND, d, v);
        chk("no_match_on_wr", d, 32'd0);
        @(negedge clk);
        csr_rd(A_PEND, d, v);
        chk("match_101", d, 32'd8);

`ifdef CSR_TIMER_PERIODIC_EN
        csr_mod(A_DIV, 3'd1, 32'd0);
        csr_mod(A_CMP0 + 12'd2, 3'd1, 32'd10);
        csr_mod(A_PER0 + 12'd2, 3'd1, 32'd10);
        csr_mod(A_EN, 3'd1, 32'd4);
        csr_mod(A_CNT, 3'd1, 32'd0);
        repeat (12) @(negedge clk);
        csr_rd(A_CMP0 + 12'd2, d, v);
        chk("per_cmp20", d, 32'd20);
        csr_rd(A_PEND, d, v);
        chk("per_pend10", d & 32'd4, 32'd4);
        csr_mod(A_PEND, 3'd3, 32'd4);
        repeat (6) @(negedge clk);
        csr_rd(A_PEND, d, v);
        chk("per_pend20", d & 32'd4, 32'd4);
        csr_rd(A_CMP0 + 12'd2, d, v);
        chk("per_cmp30", d, 32'd30);
`endif

        // Asynchronous reset while the interrupt is asserted
        csr_mod(A_EN, 3'd1, 32'hF);
        repeat (2) @(negedge clk);
        chk("irq_before_rst", 32'(irq), 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk("arst_irq", 32'(irq), 32'd0);
        chk("arst_irq_ch", 32'(irq_ch), 32'd0);
        chk("arst_valid", 32'(valid), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        csr_rd(A_PEND, d, v);
        chk("arst_pend", d, 32'd0);
        csr_rd(A_EN, d, v);
        chk("arst_en", d, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
